// File: rtl/count_2bit_pkg.sv
// count2bit_pkg: shared constants and types for the count_2bit divider.
// The default counter width gives a divide-by-4 (e.g. 100 MHz -> 25 MHz).
package count2bit_pkg;

    // Default counter width in bits; division ratio is 2**width.
    localparam int COUNT2BIT_DEFAULT_WIDTH = 2;

    // Counter value type at the default width.
    typedef logic [COUNT2BIT_DEFAULT_WIDTH-1:0] cnt_t;

endpackage : count2bit_pkg

// File: rtl/count_2bit.sv
// count_2bit: free-running binary counter used as a clock-enable/divider
// source for the VGA pixel/sync logic. clkdiv is the counter MSB, a 50 %
// duty square wave at clk / 2**WIDTH, driven straight from a flop.
//
// Optional feature: define COUNT2BIT_TICK_EN to add the registered 'tick'
// output, high for one clk cycle each time the counter wraps to zero.
module count_2bit
    import count2bit_pkg::*;
#(
    parameter int WIDTH = COUNT2BIT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic             clkdiv,
    output logic [WIDTH-1:0] count
`ifdef COUNT2BIT_TICK_EN
    ,
    output logic             tick
`endif
);

    // A zero-width counter has no MSB to divide with; stop elaboration.
    generate
        if (WIDTH < 1) begin : g_width_check
            $error("count_2bit: WIDTH must be >= 1 (got %0d)", WIDTH);
        end
    endgenerate

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;

    // Next count: increment modulo 2**WIDTH; wrap from all-ones is silent.
    always_comb begin
        cnt_next = cnt_reg + CNT_ONE;
    end

    // Counter register; reset has priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Outputs come directly from the counter flops, no logic after them.
    assign count  = cnt_reg;
    assign clkdiv = cnt_reg[WIDTH-1];

`ifdef COUNT2BIT_TICK_EN
    logic tick_reg;
    logic tick_next;

    // A wrap to zero happens on the edge where the counter holds all-ones;
    // the edge leaving reset starts from 0, so it never raises tick.
    always_comb begin
        tick_next = (cnt_reg == CNT_MAX);
    end

    // Registered wrap pulse, cleared during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= tick_next;
        end
    end

    assign tick = tick_reg;
`endif

endmodule : count_2bit

// File: tb/tb_count_2bit.sv
// tb_count_2bit: directed self-checking bench for count_2bit.
// Two instances share clk/rst: the default WIDTH=2 build and a WIDTH=3 build.
// Inputs change on falling edges; outputs are sampled on falling edges.
// When COUNT2BIT_TICK_EN is defined the tick output is checked as well.
`timescale 1ns/1ps
module tb_count_2bit;

    logic       clk;
    logic       rst;
    logic       clkdiv;
    logic [1:0] count;
    logic       clkdiv3;
    logic [2:0] count3;
`ifdef COUNT2BIT_TICK_EN
    logic       tick;
    logic       tick3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    count_2bit dut (
        .clk    (clk),
        .rst    (rst),
        .clkdiv (clkdiv),
        .count  (count)
`ifdef COUNT2BIT_TICK_EN
        ,
        .tick   (tick)
`endif
    );

    count_2bit #(.WIDTH(3)) dut3 (
        .clk    (clk),
        .rst    (rst),
        .clkdiv (clkdiv3),
        .count  (count3)
`ifdef COUNT2BIT_TICK_EN
        ,
        .tick   (tick3)
`endif
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset asserted 10-20 ns: captured by the 15 ns edge.
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (count !== 2'd0) begin
            n_bad++; $display("FAIL reset_count: got %0d want 0", count);
        end
        n_cmp++;
        if (clkdiv !== 1'b0) begin
            n_bad++; $display("FAIL reset_clkdiv: got %b want 0", clkdiv);
        end
        n_cmp++;
        if (count3 !== 3'd0) begin
            n_bad++; $display("FAIL reset_count3: got %0d want 0", count3);
        end
`ifdef COUNT2BIT_TICK_EN
        n_cmp++;
        if (tick !== 1'b0) begin
            n_bad++; $display("FAIL reset_tick: got %b want 0", tick);
        end
`endif
        $display("reset: count=%0d clkdiv=%b", count, clkdiv);
        rst = 1'b0;
    endtask

    // Free run right after reset: 1,2,3,0,1,2,3,0 with clkdiv high on 2,3.
    task automatic test_free_run();
        logic [1:0] exp_cnt [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic       exp_div [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       exp_tck [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (count !== exp_cnt[i]) begin
                n_bad++; $display("FAIL free_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]);
            end
            n_cmp++;
            if (clkdiv !== exp_div[i]) begin
                n_bad++; $display("FAIL free_clkdiv[%0d]: got %b want %b", i, clkdiv, exp_div[i]);
            end
`ifdef COUNT2BIT_TICK_EN
            n_cmp++;
            if (tick !== exp_tck[i]) begin
                n_bad++; $display("FAIL free_tick[%0d]: got %b want %b", i, tick, exp_tck[i]);
            end
`else
            if (exp_tck[i] === 1'bx) $display("unreachable");
`endif
            $display("free[%0d]: count=%0d clkdiv=%b", i, count, clkdiv);
        end
    endtask

    // Counter is at 0 here. Run to 2, reset one edge, then resume at 1.
    task automatic test_reset_mid();
        logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        logic       exp_div [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (count !== exp_cnt[i]) begin
                n_bad++; $display("FAIL mid_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]);
            end
            n_cmp++;
            if (clkdiv !== exp_div[i]) begin
                n_bad++; $display("FAIL mid_clkdiv[%0d]: got %b want %b", i, clkdiv, exp_div[i]);
            end
`ifdef COUNT2BIT_TICK_EN
            n_cmp++;
            if (tick !== 1'b0) begin
                n_bad++; $display("FAIL mid_tick[%0d]: got %b want 0", i, tick);
            end
`endif
            $display("mid[%0d]: rst=%b count=%0d clkdiv=%b", i, rst, count, clkdiv);
            rst = (i == 1);
        end
    endtask

    // Counter is at 1 here. Hold reset for 5 edges, then resume at 1.
    task automatic test_reset_hold();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (count !== 2'd0 || clkdiv !== 1'b0) begin
                n_bad++; $display("FAIL hold[%0d]: got count=%0d clkdiv=%b want 0/0", i, count, clkdiv);
            end
`ifdef COUNT2BIT_TICK_EN
            n_cmp++;
            if (tick !== 1'b0) begin
                n_bad++; $display("FAIL hold_tick[%0d]: got %b want 0", i, tick);
            end
`endif
            $display("hold[%0d]: count=%0d clkdiv=%b", i, count, clkdiv);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (count !== 2'd1) begin
            n_bad++; $display("FAIL hold_resume: got %0d want 1", count);
        end
`ifdef COUNT2BIT_TICK_EN
        n_cmp++;
        if (tick !== 1'b0) begin
            n_bad++; $display("FAIL hold_exit_tick: got %b want 0", tick);
        end
`endif
        $display("hold_resume: count=%0d", count);
    endtask

    // WIDTH=3 instance: 16 edges after reset, period 8, high on 4..7, wrap 7->0.
    task automatic test_width3();
        logic [2:0] exp_cnt [16] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0,
                                     3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        logic       exp_div [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int high_cnt = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (clkdiv3 === 1'b1) high_cnt++;
            n_cmp++;
            if (count3 !== exp_cnt[i] || clkdiv3 !== exp_div[i]) begin
                n_bad++;
                $display("FAIL w3[%0d]: got count=%0d clkdiv=%b want %0d/%b",
                         i, count3, clkdiv3, exp_cnt[i], exp_div[i]);
            end
            $display("w3[%0d]: count=%0d clkdiv=%b", i, count3, clkdiv3);
        end
        n_cmp++;
        if (high_cnt != 8) begin
            n_bad++; $display("FAIL w3_duty: got %0d high cycles want 8", high_cnt);
        end
    endtask

    // A rst pulse between rising edges must be ignored; tick keeps cadence.
    task automatic test_back_to_back();
        logic [1:0] exp_cnt [6] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        logic       exp_tck [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);      // count = 1
        #1 rst = 1'b1;       // pulse from negedge+1 to negedge+3, edge at +5
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (count !== exp_cnt[i]) begin
                n_bad++; $display("FAIL glitch_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]);
            end
`ifdef COUNT2BIT_TICK_EN
            n_cmp++;
            if (tick !== exp_tck[i]) begin
                n_bad++; $display("FAIL glitch_tick[%0d]: got %b want %b", i, tick, exp_tck[i]);
            end
`else
            if (exp_tck[i] === 1'bx) $display("unreachable");
`endif
            $display("glitch[%0d]: count=%0d", i, count);
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_free_run();
        test_reset_mid();
        test_reset_hold();
        test_width3();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_count_2bit
